demux_stream_ctrl: RTL and testbench
====================================

Name: demux_stream_ctrl

Overview:
- Sequencing controller in front of the 1-to-4 demultiplexer.
- Accepts a valid/ready input stream and registers each item in a one-entry output stage.
- Steers the item to one of four output channels, chosen by an explicit destination or by round-robin, and drives the demux select lines s1/s0.
- Keeps per-channel saturating transfer counters, readable through a small read port.

Parameters:
- WIDTH, 8, data width of in_data/out_data.
- CNT_W, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input item present.
- in_ready  output  1  controller can accept the input item this cycle.
- in_data  input  WIDTH  input payload.
- in_dest  input  2  requested channel; used only when auto_mode=0.
- auto_mode  input  1  1 = round-robin channel choice, 0 = in_dest.
- out_valid  output  4  one-hot; bit k means out_data is valid for channel k.
- out_ready  input  4  per-channel accept.
- out_data  output  WIDTH  registered payload, shared by all channels.
- s1  output  1  demux select MSB, equal to sel[1].
- s0  output  1  demux select LSB, equal to sel[0].
- clr_cnt  input  1  synchronous clear of all counters.
- cnt_sel  input  2  counter read index.
- cnt_out  output  CNT_W  combinational read of counter[cnt_sel].

Behaviour:
- Reset (rst=1 at a clk edge): busy=0, sel=0, rr_ptr=0, out_data=0, out_valid=0000, s1=s0=0, all counters 0. rst overrides every other input, including mid-transfer; a held item is dropped and not counted.
- State: busy (1 bit), sel[1:0], out_data, rr_ptr[1:0].
  - IDLE = busy 0; FULL = busy 1.
- out_valid = busy ? (1 << sel) : 0000. Exactly one bit high or none.
- Definitions:
  - xfer_out = busy & out_ready[sel]. Only out_ready of the selected channel matters; the other three bits are ignored.
  - in_ready = !busy | xfer_out. This is a combinational path from out_ready, so back-to-back throughput is 1 item/cycle.
  - xfer_in = in_valid & in_ready.
- Capture: on xfer_in, at the next edge:
  - out_data <= in_data;
  - sel <= auto_mode ? rr_ptr : in_dest;
  - busy <= 1.
- Latency: an item accepted at edge N appears on out_valid/out_data after edge N, i.e. one cycle.
- Drain: on xfer_out without xfer_in, busy <= 0 at the next edge; sel and out_data hold their values.
- Simultaneous xfer_out and xfer_in: busy stays 1 and the new item replaces the old one with no bubble.
- Hold: while busy & !out_ready[sel]:
  - out_data, sel and out_valid are stable;
  - in_ready=0;
  - in_valid/in_data may change freely without effect.
- Round-robin: on every xfer_in with auto_mode=1, rr_ptr <= rr_ptr+1 mod 4 (3 wraps to 0). rr_ptr is unchanged when auto_mode=0.
- auto_mode changes take effect only at the next capture; an item already held keeps its sel.
- s1/s0 track sel in both states. They are meaningful to the demux only while busy=1.
- Counters:
  - on xfer_out, counter[sel] increments, saturating at 2^CNT_W-1 (no wrap);
  - clr_cnt=1 zeroes all four counters and takes priority over a simultaneous increment, so that transfer is not counted;
  - cnt_out is a pure mux of the counter registers and reflects an update on the cycle after the edge.
- in_valid=0 with busy=0: nothing changes.
- X on in_data is permitted when in_valid=0.

Test Plan:
- Reset then single item: auto_mode=0, in_dest=2, in_data=8'hA5, out_ready=1111 → next cycle out_valid=0100, out_data=A5, s1=1, s0=0; then busy clears and cnt_sel=2 reads 1.
- Backpressure: in_dest=1, out_ready=0000 for 5 cycles → out_valid=0010 stable, in_ready=0, data held; set out_ready[1]=1 → transfer, counter1=1. Holding out_ready=1101 instead must never drain the item.
- Round-robin streaming: auto_mode=1, out_ready=1111, 8 back-to-back items 0..7 → one item per cycle, out_valid sequence 0001,0010,0100,1000 repeated, every counter ends at 2.
- Saturation and clear: CNT_W=8, 260 transfers to channel 3 → cnt_out=255. clr_cnt asserted on the same cycle as a transfer → all counters 0 afterwards.
- Reset mid-operation: item held with out_ready=0, assert rst one cycle → out_valid=0000, s1=s0=0, counters 0, rr_ptr restarts at channel 0.
- Mode switch while FULL: item captured with auto_mode=0, in_dest=3; toggle auto_mode to 1 before drain → item still exits on channel 3, next item goes to rr_ptr=0.

Source files
------------

// File: rtl/demux_stream_ctrl.sv
// Stream controller feeding a 1-to-4 demux: one-entry registered output stage with 1-cycle latency.
// in_ready drops only while the held item's selected channel refuses it; per-channel saturating counters.
module demux_stream_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    input  logic             auto_mode,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             s1,
    output logic             s0,
    input  logic             clr_cnt,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic             busy;
    logic [1:0]       sel;
    logic [1:0]       rr_ptr;
    logic             xfer_out;
    logic             xfer_in;
    logic [CNT_W-1:0] cnt [4];

    assign busy     = (state == FULL);
    // Only the selected channel's ready matters; this combinational path gives full throughput.
    assign xfer_out = busy & out_ready[sel];
    assign in_ready = ~busy | xfer_out;
    assign xfer_in  = in_valid & in_ready;

    assign out_valid = busy ? (4'b0001 << sel) : 4'b0000;
    assign s1        = sel[1];
    assign s0        = sel[0];
    assign cnt_out   = cnt[cnt_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 2'd0;
            rr_ptr   <= 2'd0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer_in) begin
                        state    <= FULL;
                        out_data <= in_data;
                        sel      <= auto_mode ? rr_ptr : in_dest;
                        if (auto_mode) begin
                            rr_ptr <= rr_ptr + 2'd1;
                        end
                    end
                end
                FULL: begin
                    // A capture on the draining cycle replaces the item with no bubble.
                    if (xfer_in) begin
                        out_data <= in_data;
                        sel      <= auto_mode ? rr_ptr : in_dest;
                        if (auto_mode) begin
                            rr_ptr <= rr_ptr + 2'd1;
                        end
                    end else if (xfer_out) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= '0;
            end
        end else if (xfer_out && (cnt[sel] != CNT_MAX)) begin
            cnt[sel] <= cnt[sel] + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux_stream_ctrl.sv
// Scoreboard bench for demux_stream_ctrl: directed scenarios followed by randomized traffic.
module tb_demux_stream_ctrl;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       in_dest = 2'd0;
    logic             auto_mode = 1'b0;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready = 4'b0000;
    logic [WIDTH-1:0] out_data;
    logic             s1;
    logic             s0;
    logic             clr_cnt = 1'b0;
    logic [1:0]       cnt_sel = 2'd0;
    logic [CNT_W-1:0] cnt_out;

    demux_stream_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .auto_mode (auto_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .s1        (s1),
        .s0        (s0),
        .clr_cnt   (clr_cnt),
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int chan;
        int data;
    } item_t;

    // Reference model: items in flight, round-robin position, last chosen channel, counters.
    item_t q[$];
    int    rr_m = 0;
    int    last_sel = 0;
    int    cnt_m [4] = '{0, 0, 0, 0};
    int    n_total = 0;
    int    n_pass  = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endfunction

    // Issue side: record each accepted item with the channel the rules assign to it.
    always @(negedge clk) begin
        #1;
        if (!rst && in_valid && in_ready) begin
            item_t it;
            it.chan = auto_mode ? rr_m : int'(in_dest);
            it.data = int'(in_data);
            if (auto_mode) rr_m = (rr_m + 1) % 4;
            last_sel = it.chan;
            q.push_back(it);
        end
    end

    // Monitor: compare what the DUT presents against the oldest outstanding item.
    always @(negedge clk) begin
        int exp_valid;
        int exp_sel;
        exp_valid = 0;
        exp_sel   = last_sel;
        if (q.size() > 0) begin
            exp_sel   = q[0].chan;
            exp_valid = 1 << q[0].chan;
        end
        chk("out_valid", int'(out_valid), exp_valid);
        chk("s1s0", int'({s1, s0}), exp_sel);
        if (q.size() > 0) chk("out_data", int'(out_data), q[0].data);
        chk("in_ready", int'(in_ready), int'(q.size() == 0 || out_ready[exp_sel]));
        chk("cnt_out", int'(cnt_out), cnt_m[cnt_sel]);
        if (rst) begin
            q.delete();
            rr_m     = 0;
            last_sel = 0;
            cnt_m    = '{0, 0, 0, 0};
        end else begin
            if (q.size() > 0 && out_ready[exp_sel]) begin
                void'(q.pop_front());
                if (!clr_cnt && cnt_m[exp_sel] < CNT_MAX) cnt_m[exp_sel]++;
            end
            if (clr_cnt) cnt_m = '{0, 0, 0, 0};
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] dest,
                       input logic am, input logic [3:0] ordy, input logic clr,
                       input logic [1:0] cs, input logic r, input int n);
        in_valid  = v;
        in_data   = d;
        in_dest   = dest;
        auto_mode = am;
        out_ready = ordy;
        clr_cnt   = clr;
        cnt_sel   = cs;
        rst       = r;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cyc(0, 8'h00, 2'd0, 0, 4'b0000, 0, 2'd0, 1, 2);

        // Single item to channel 2, then read its counter.
        cyc(1, 8'hA5, 2'd2, 0, 4'b1111, 0, 2'd2, 0, 1);
        cyc(0, 8'h00, 2'd0, 0, 4'b1111, 0, 2'd2, 0, 3);

        // Backpressure on channel 1; other channels' ready must not drain it.
        cyc(1, 8'h3C, 2'd1, 0, 4'b0000, 0, 2'd1, 0, 1);
        cyc(1, 8'hFF, 2'd2, 0, 4'b0000, 0, 2'd1, 0, 5);
        cyc(0, 8'h00, 2'd0, 0, 4'b1101, 0, 2'd1, 0, 4);
        cyc(0, 8'h00, 2'd0, 0, 4'b0010, 0, 2'd1, 0, 2);

        // Round-robin streaming, eight back-to-back items.
        for (int i = 0; i < 8; i++) cyc(1, 8'(i), 2'd3, 1, 4'b1111, 0, 2'(i), 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 2'd0, 1, 4'b1111, 0, 2'(i), 0, 1);

        // Saturation on channel 3.
        cyc(1, 8'h5A, 2'd3, 0, 4'b1111, 0, 2'd3, 0, 260);
        cyc(0, 8'h00, 2'd0, 0, 4'b1111, 0, 2'd3, 0, 2);

        // Clear on the same cycle as a transfer.
        cyc(1, 8'h55, 2'd0, 0, 4'b0000, 0, 2'd0, 0, 1);
        cyc(0, 8'h00, 2'd0, 0, 4'b1111, 1, 2'd0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 2'd0, 0, 4'b1111, 0, 2'(i), 0, 1);

        // Reset while an item is held; round-robin restarts at channel 0.
        cyc(1, 8'h77, 2'd2, 1, 4'b0000, 0, 2'd0, 0, 2);
        cyc(1, 8'h66, 2'd2, 1, 4'b0000, 0, 2'd0, 1, 1);
        cyc(1, 8'h88, 2'd2, 1, 4'b1111, 0, 2'd0, 0, 1);
        cyc(0, 8'h00, 2'd0, 1, 4'b1111, 0, 2'd0, 0, 2);

        // Mode switch while full: held item keeps channel 3.
        cyc(1, 8'h99, 2'd3, 0, 4'b0000, 0, 2'd3, 0, 1);
        cyc(0, 8'h00, 2'd1, 1, 4'b0000, 0, 2'd3, 0, 2);
        cyc(1, 8'hAA, 2'd1, 1, 4'b1000, 0, 2'd1, 0, 1);
        cyc(0, 8'h00, 2'd0, 1, 4'b1111, 0, 2'd1, 0, 2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), 1'($urandom),
                (($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111),
                ($urandom_range(0, 49) == 0), 2'($urandom),
                ($urandom_range(0, 199) == 0), 1);
        end

        cyc(0, 8'h00, 2'd0, 0, 4'b1111, 0, 2'd0, 0, 4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
